// File: rtl/wb_tia_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the TIA port.
// 'master' is the arbiter's view, 'slave' is the surrounding system.
interface wb_tia_arbiter_if #(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 7
);
  logic                     m0_stb_i;
  logic                     m0_we_i;
  logic [WB_ADDR_WIDTH-1:0] m0_adr_i;
  logic [WB_DATA_WIDTH-1:0] m0_dat_i;
  logic                     m0_ack_o;
  logic                     m0_err_o;
  logic [WB_DATA_WIDTH-1:0] m0_dat_o;
  logic                     m1_stb_i;
  logic                     m1_we_i;
  logic [WB_ADDR_WIDTH-1:0] m1_adr_i;
  logic [WB_DATA_WIDTH-1:0] m1_dat_i;
  logic                     m1_ack_o;
  logic                     m1_err_o;
  logic [WB_DATA_WIDTH-1:0] m1_dat_o;
  logic                     s_stb_o;
  logic                     s_we_o;
  logic [WB_ADDR_WIDTH-1:0] s_adr_o;
  logic [WB_DATA_WIDTH-1:0] s_dat_o;
  logic                     s_ack_i;
  logic [WB_DATA_WIDTH-1:0] s_dat_i;
  logic [1:0]               grant_o;

  modport master (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  s_ack_i, s_dat_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output grant_o
  );

  modport slave (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output s_ack_i, s_dat_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  grant_o
  );
endinterface

// File: rtl/wb_tia_arbiter.sv
// Round-robin two-master arbiter for the TIA register port.
// Each grant yields exactly one single-cycle strobe to the TIA.
module wb_tia_arbiter #(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 7,
  parameter int TIMEOUT       = 15
) (
  input logic                clk_i,
  input logic                rst_ni,
  wb_tia_arbiter_if.master   bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;
  localparam logic [7:0] TO   = 8'(TIMEOUT);

  logic [2:0]               state;
  logic                     sel;
  logic                     last_grant;
  logic [7:0]               cnt;
  logic                     stb_q;
  logic                     we_q;
  logic [WB_ADDR_WIDTH-1:0] adr_q;
  logic [WB_DATA_WIDTH-1:0] dat_q;
  logic [1:0]               ack_q;
  logic [1:0]               err_q;
  logic [WB_DATA_WIDTH-1:0] m0_dat_q;
  logic [WB_DATA_WIDTH-1:0] m1_dat_q;
  logic [1:0]               grant_q;
  logic                     pick;
  logic                     any_req;

  // Choose the next owner; on a tie the one not served last wins.
  always_comb begin
    pick    = 1'b0;
    any_req = bus.m0_stb_i | bus.m1_stb_i;
    unique case ({bus.m1_stb_i, bus.m0_stb_i})
      2'b11:   pick = ~last_grant;
      2'b10:   pick = 1'b1;
      default: pick = 1'b0;
    endcase
  end

  // Sequencer: grant, strobe once, wait for ack or timeout, settle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 8'd0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      m0_dat_q   <= '0;
      m1_dat_q   <= '0;
      grant_q    <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            sel        <= pick;
            last_grant <= pick;
            grant_q    <= pick ? 2'b10 : 2'b01;
            we_q       <= pick ? bus.m1_we_i
                               : bus.m0_we_i;
            adr_q      <= pick ? bus.m1_adr_i
                               : bus.m0_adr_i;
            dat_q      <= pick ? bus.m1_dat_i
                               : bus.m0_dat_i;
            stb_q      <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          stb_q <= 1'b0;
          cnt   <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.s_ack_i) begin
            ack_q[sel] <= 1'b1;
            if (sel) m1_dat_q <= bus.s_dat_i;
            else     m0_dat_q <= bus.s_dat_i;
            state <= DONE;
          end else if (cnt == TO) begin
            err_q[sel] <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          ack_q <= 2'b00;
          err_q <= 2'b00;
          state <= HOLD;
        end
        HOLD: begin
          grant_q <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_stb_o  = stb_q;
  assign bus.s_we_o   = we_q;
  assign bus.s_adr_o  = adr_q;
  assign bus.s_dat_o  = dat_q;
  assign bus.m0_ack_o = ack_q[0];
  assign bus.m0_err_o = err_q[0];
  assign bus.m0_dat_o = m0_dat_q;
  assign bus.m1_ack_o = ack_q[1];
  assign bus.m1_err_o = err_q[1];
  assign bus.m1_dat_o = m1_dat_q;
  assign bus.grant_o  = grant_q;
endmodule

// File: tb/tb_wb_tia_arbiter.sv
// Bench for wb_tia_arbiter: vector table, tie, reset-in-WAIT.
// Scoreboard queues hold expected slave strobes and responses.
module tb_wb_tia_arbiter;
  localparam int DW = 8;
  localparam int AW = 7;

  typedef struct {
    logic          m;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    int            lat;
    logic          exp_err;
    int            exp_cyc;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } slv_t;

  typedef struct {
    logic          m;
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_tia_arbiter_if #(
    .WB_DATA_WIDTH(DW),
    .WB_ADDR_WIDTH(AW)
  ) bus ();

  wb_tia_arbiter #(
    .WB_DATA_WIDTH(DW),
    .WB_ADDR_WIDTH(AW),
    .TIMEOUT(15)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  slv_t          exp_slv[$];
  rsp_t          exp_rsp[$];
  int            checks = 0;
  int            failures = 0;
  int            ack_lat = 1;
  logic [DW-1:0] rd_val = '0;
  logic [DW-1:0] last_dat [2];
  vec_t          vecs [7];

  // TIA model: ack ack_lat cycles after seeing the strobe (0 = never)
  initial begin
    int pend;
    pend = 0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.s_ack_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.s_ack_i = 1'b1;
          bus.s_dat_i = rd_val;
        end
      end
      if (bus.s_stb_o && ack_lat > 0) pend = ack_lat;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic stb,
                       input logic we,
                       input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat);
    if (m) begin
      bus.m1_stb_i = stb;
      bus.m1_we_i  = we;
      bus.m1_adr_i = adr;
      bus.m1_dat_i = dat;
    end else begin
      bus.m0_stb_i = stb;
      bus.m0_we_i  = we;
      bus.m0_adr_i = adr;
      bus.m0_dat_i = dat;
    end
  endtask

  task automatic expect_xfer(input logic m, input logic we,
                             input logic [AW-1:0] adr,
                             input logic [DW-1:0] wdat,
                             input logic err,
                             input logic [DW-1:0] rdat);
    slv_t s;
    rsp_t r;
    s.we  = we;
    s.adr = adr;
    s.dat = wdat;
    exp_slv.push_back(s);
    if (!err) last_dat[m] = rdat;
    r.m   = m;
    r.err = err;
    r.dat = last_dat[m];
    exp_rsp.push_back(r);
  endtask

  task automatic monitor();
    logic          prev;
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
    slv_t          s;
    rsp_t          r;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.s_stb_o === 1'b1) begin
        chk("stb_single", prev, 0);
        chk("stb_expected", exp_slv.size() > 0, 1);
        if (exp_slv.size() > 0) begin
          s = exp_slv.pop_front();
          chk("s_we", bus.s_we_o, s.we);
          chk("s_adr", bus.s_adr_o, s.adr);
          chk("s_dat", bus.s_dat_o, s.dat);
        end
      end
      prev = bus.s_stb_o;
      for (int m = 0; m < 2; m++) begin
        ack = m ? bus.m1_ack_o : bus.m0_ack_o;
        err = m ? bus.m1_err_o : bus.m0_err_o;
        dat = m ? bus.m1_dat_o : bus.m0_dat_o;
        if (ack || err) begin
          chk("rsp_expected", exp_rsp.size() > 0, 1);
          if (exp_rsp.size() > 0) begin
            r = exp_rsp.pop_front();
            chk("rsp_master", m, r.m);
            chk("rsp_err", err, r.err);
            chk("rsp_ack", ack, !r.err);
            chk("rsp_dat", dat, r.dat);
          end
        end
      end
    end
  endtask

  task automatic xfer(input vec_t v, input string tag);
    int         c;
    int         g;
    logic       other;
    logic       mine;
    logic [1:0] oh;
    c     = 0;
    g     = 0;
    other = 1'b0;
    oh    = v.m ? 2'b10 : 2'b01;
    ack_lat = v.lat;
    rd_val  = v.rdat;
    expect_xfer(v.m, v.we, v.adr, v.wdat,
                v.exp_err, v.rdat);
    drive(v.m, 1'b1, v.we, v.adr, v.wdat);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk({tag, "_grant"}, bus.grant_o, oh);
        drive(v.m, 1'b1, ~v.we, v.adr ^ 7'h55,
              v.wdat ^ 8'hFF);
      end
      if (bus.grant_o == oh) g++;
      if (v.m) begin
        other = other | bus.m0_ack_o | bus.m0_err_o;
        mine  = bus.m1_ack_o | bus.m1_err_o;
      end else begin
        other = other | bus.m1_ack_o | bus.m1_err_o;
        mine  = bus.m0_ack_o | bus.m0_err_o;
      end
      if (mine) begin
        c = k;
        break;
      end
    end
    chk({tag, "_latency"}, c, v.exp_cyc);
    drive(v.m, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    if (bus.grant_o == oh) g++;
    other = other | (v.m ? bus.m0_ack_o : bus.m1_ack_o);
    chk({tag, "_grant_len"}, g, v.exp_cyc + 1);
    @(posedge clk);
    #1;
    chk({tag, "_grant_idle"}, bus.grant_o, 0);
    chk({tag, "_other_quiet"}, other, 0);
    chk({tag, "_stb_done"}, exp_slv.size(), 0);
  endtask

  initial begin
    int   n;
    logic seen;
    vec_t v;

    // m, we, adr, wdat, rdat, lat, exp_err, exp_cyc
    vecs[0] = '{1'b0, 1'b1, 7'h09, 8'h84, 8'h00, 1, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b0, 7'h0C, 8'h00, 8'h80, 1, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b0, 7'h0D, 8'h00, 8'h5A, 3, 1'b0, 5};
    vecs[3] = '{1'b1, 1'b1, 7'h2A, 8'h11, 8'h6E, 2, 1'b0, 4};
    vecs[4] = '{1'b0, 1'b0, 7'h01, 8'h00, 8'hEE, 0, 1'b1, 18};
    vecs[5] = '{1'b0, 1'b0, 7'h02, 8'h00, 8'hC3, 16, 1'b0, 18};
    vecs[6] = '{1'b1, 1'b0, 7'h7F, 8'h00, 8'hFF, 1, 1'b0, 3};

    last_dat[0] = '0;
    last_dat[1] = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slave", {bus.grant_o, bus.s_stb_o, bus.s_we_o,
                      bus.s_adr_o, bus.s_dat_o}, 0);
    chk("rst_master", {bus.m0_ack_o, bus.m0_err_o,
                       bus.m0_dat_o, bus.m1_ack_o,
                       bus.m1_err_o, bus.m1_dat_o}, 0);
    rst_n = 1'b1;

    // both request continuously from reset: m0,m1,m0,m1
    ack_lat = 1;
    rd_val  = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      expect_xfer(1'b0, 1'b1, 7'h10, 8'hA0, 1'b0, 8'h3C);
      expect_xfer(1'b1, 1'b0, 7'h11, 8'h22, 1'b0, 8'h3C);
    end
    drive(1'b0, 1'b1, 1'b1, 7'h10, 8'hA0);
    drive(1'b1, 1'b1, 1'b0, 7'h11, 8'h22);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.m0_ack_o || bus.m1_ack_o) n++;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("tie_done_in_20", n, 4);
    chk("tie_drained", exp_rsp.size(), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      xfer(v, $sformatf("vec%0d", i));
    end

    // reset while waiting for a slow ack; the ack lands later
    ack_lat = 4;
    rd_val  = 8'h99;
    begin
      slv_t s;
      s.we  = 1'b0;
      s.adr = 7'h05;
      s.dat = 8'h00;
      exp_slv.push_back(s);
    end
    drive(1'b0, 1'b1, 1'b0, 7'h05, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rw_grant_before", bus.grant_o, 2'b01);
    #2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rw_slave_zero", {bus.grant_o, bus.s_stb_o, bus.s_we_o,
                          bus.s_adr_o, bus.s_dat_o}, 0);
    chk("rw_master_zero", {bus.m0_ack_o, bus.m0_err_o,
                           bus.m0_dat_o, bus.m1_ack_o,
                           bus.m1_err_o, bus.m1_dat_o}, 0);
    last_dat[0] = '0;
    last_dat[1] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      seen = seen | bus.m0_ack_o | bus.m0_err_o
                  | bus.m1_ack_o | bus.m1_err_o
                  | (bus.grant_o != 2'b00);
    end
    chk("rw_late_ack_ignored", seen, 0);
    v = '{1'b1, 1'b0, 7'h0C, 8'h00, 8'h47, 1, 1'b0, 3};
    xfer(v, "post_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_drained", exp_rsp.size(), 0);
    chk("slv_drained", exp_slv.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
